// File: rtl/xmodem_send_arbiter.sv
// Round-robin arbiter that shares one xmodem sender among NREQ requesters,
// relaunching on timeout and reporting ok/fail to the owning requester.
module xmodem_send_arbiter #(
  parameter int NREQ      = 4,
  parameter int ADDR_W    = 16,
  parameter int TIMEOUT   = 1 << 20,
  parameter int MAX_RETRY = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NREQ-1:0]        i_req,
  input  logic [5*NREQ-1:0]      i_req_len,
  input  logic [ADDR_W*NREQ-1:0] i_req_base,
  output logic [NREQ-1:0]        o_grant,
  output logic [NREQ-1:0]        o_rsp_ok,
  output logic [NREQ-1:0]        o_rsp_fail,
  output logic                   o_send_data,
  output logic [4:0]             o_data_length,
  input  logic [31:0]            i_data_addr,
  input  logic [6:0]             i_byte_addr,
  output logic [7:0]             o_data,
  input  logic                   i_done,
  output logic [ADDR_W-1:0]      o_mem_addr,
  input  logic [7:0]             i_mem_rdata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            r_state;
  logic [NREQ-1:0]   r_grant;
  logic [NREQ-1:0]   r_ok;
  logic [NREQ-1:0]   r_fail;
  logic              r_send;
  logic [4:0]        r_dlen;
  logic [IW-1:0]     r_idx;
  logic [4:0]        r_len;
  logic [ADDR_W-1:0] r_base;
  logic [RW-1:0]     r_retry;
  logic [TW-1:0]     r_timer;
  logic [IW-1:0]     r_rr;

  logic              w_any;
  logic [IW-1:0]     w_pick;
  logic [IW-1:0]     w_cand;
  logic [4:0]        w_len;
  logic [ADDR_W-1:0] w_base;
  logic [NREQ-1:0]   w_onehot;
  logic [38:0]       w_offset;
  logic              w_unused_addr_bits;

  // Scan from the requester after the last owner; the nearest set bit wins.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_cand = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_cand = IW'((int'(r_rr) + k) % NREQ);
      if (i_req[w_cand]) begin
        w_any  = 1'b1;
        w_pick = w_cand;
      end
    end
  end

  assign w_len    = i_req_len[5*int'(w_pick) +: 5];
  assign w_base   = i_req_base[ADDR_W*int'(w_pick) +: ADDR_W];
  assign w_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_pick;

  // Block index and byte index form one linear offset; the sum wraps at the buffer size.
  assign w_offset           = {i_data_addr, i_byte_addr};
  assign w_unused_addr_bits = ^w_offset[38:ADDR_W];
  assign o_mem_addr         = r_base + w_offset[ADDR_W-1:0];
  assign o_data             = i_mem_rdata;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_ok    <= '0;
      r_fail  <= '0;
      r_send  <= 1'b0;
      r_dlen  <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_base  <= '0;
      r_retry <= '0;
      r_timer <= '0;
      r_rr    <= IW'(NREQ - 1);
    end else begin
      r_send <= 1'b0;
      r_ok   <= '0;
      r_fail <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_idx   <= w_pick;
            r_len   <= w_len;
            r_base  <= w_base;
            r_retry <= '0;
            r_grant <= w_onehot;
            if (w_len == 5'd0) begin
              r_fail  <= w_onehot;
              r_state <= S_RESP;
            end else begin
              r_state <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          r_send  <= 1'b1;
          r_dlen  <= r_len;
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_timer <= r_timer + 1'b1;
          // Completion takes precedence over a timeout landing in the same cycle.
          if (i_done) begin
            r_ok    <= r_grant;
            r_state <= S_RESP;
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            if (r_retry < RW'(MAX_RETRY)) begin
              r_retry <= r_retry + 1'b1;
              r_state <= S_LAUNCH;
            end else begin
              r_fail  <= r_grant;
              r_state <= S_RESP;
            end
          end
        end
        S_RESP: begin
          r_rr    <= r_idx;
          r_grant <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_grant       = r_grant;
  assign o_rsp_ok      = r_ok;
  assign o_rsp_fail    = r_fail;
  assign o_send_data   = r_send;
  assign o_data_length = r_dlen;

endmodule

// File: tb/tb_xmodem_send_arbiter.sv
// Directed bench for xmodem_send_arbiter: a cycle-scheduled transaction model
// checked every cycle, plus hand-computed literal expectations per scenario.
module tb_xmodem_send_arbiter;

   localparam int NREQ      = 4;
   localparam int ADDR_W    = 16;
   localparam int TIMEOUT   = 16;
   localparam int MAX_RETRY = 3;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req = '0;
   logic [19:0] reqLen = '0;
   logic [63:0] reqBase = '0;
   logic [31:0] dataAddr = '0;
   logic [6:0]  byteAddr = '0;
   logic        done = 1'b0;
   logic [7:0]  memRdata;

   logic [3:0]  grant, rspOk, rspFail;
   logic        sendData;
   logic [4:0]  dataLength;
   logic [7:0]  data;
   logic [15:0] memAddr;

   int checks = 0;
   int errors = 0;

   xmodem_send_arbiter #(
      .NREQ(NREQ), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)
   ) dut (
      .i_clk(clock), .i_rst(reset), .i_req(req), .i_req_len(reqLen), .i_req_base(reqBase),
      .o_grant(grant), .o_rsp_ok(rspOk), .o_rsp_fail(rspFail), .o_send_data(sendData),
      .o_data_length(dataLength), .i_data_addr(dataAddr), .i_byte_addr(byteAddr),
      .o_data(data), .i_done(done), .o_mem_addr(memAddr), .i_mem_rdata(memRdata)
   );

   always #5 clock = ~clock;

   // Buffer RAM contents: a fixed scramble of the address.
   function automatic logic [7:0] ramByte(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   assign memRdata = ramByte(memAddr);

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: each transfer is a schedule of cycle numbers
   // (launch pulse, response) derived from arbitration and timeout rules.
   int          cyc = 0;
   bit          modelValid = 1'b0;
   int          mOwner = -1;
   int          mRr = NREQ - 1;
   int          mSendAt = -1;
   int          mRespAt = -1;
   bit          mRespOk = 1'b0;
   int          mAttempts = 0;
   int          pick;
   logic [4:0]  mLen = '0;
   logic [4:0]  expLen = '0;
   logic [15:0] mBase = '0;
   logic [3:0]  expGrant;
   logic [38:0] off;
   logic [15:0] expAddr;

   always begin
      @(posedge clock);
      if (reset) begin
         mOwner = -1; mRr = NREQ - 1; mSendAt = -1; mRespAt = -1;
         mRespOk = 1'b0; mAttempts = 0; expLen = '0; modelValid = 1'b1;
      end else if (modelValid) begin
         if (mOwner < 0) begin
            pick = -1;
            for (int k = 1; k <= NREQ; k++)
               if (pick < 0 && req[(mRr + k) % NREQ]) pick = (mRr + k) % NREQ;
            if (pick >= 0) begin
               mOwner = pick;
               mLen = reqLen[5*pick +: 5];
               mBase = reqBase[16*pick +: 16];
               mAttempts = 0;
               if (mLen == 5'd0) begin
                  mRespAt = cyc + 1; mRespOk = 1'b0;
               end else begin
                  mSendAt = cyc + 2;
               end
            end
         end else if (mRespAt == cyc) begin
            mRr = mOwner; mOwner = -1; mRespAt = -1; mSendAt = -1;
         end else if (mRespAt < 0 && mSendAt >= 0 && cyc >= mSendAt && cyc <= mSendAt + TIMEOUT - 1) begin
            if (done) begin
               mRespAt = cyc + 1; mRespOk = 1'b1;
            end else if (cyc == mSendAt + TIMEOUT - 1) begin
               if (mAttempts < MAX_RETRY) begin
                  mAttempts++; mSendAt = cyc + 2;
               end else begin
                  mRespAt = cyc + 1; mRespOk = 1'b0;
               end
            end
         end
         if (mOwner >= 0 && mSendAt == cyc + 1) expLen = mLen;
      end
      cyc++;
      #1;
      if (modelValid) begin
         expGrant = (mOwner >= 0) ? (4'b0001 << mOwner) : 4'b0000;
         checkOutput("grant", grant, expGrant);
         checkOutput("sendData", sendData, (mOwner >= 0 && mSendAt == cyc));
         checkOutput("dataLength", dataLength, expLen);
         checkOutput("rspOk", rspOk, (mOwner >= 0 && mRespAt == cyc && mRespOk) ? expGrant : 4'b0);
         checkOutput("rspFail", rspFail, (mOwner >= 0 && mRespAt == cyc && !mRespOk) ? expGrant : 4'b0);
         if (mOwner >= 0) begin
            off = {dataAddr, byteAddr};
            expAddr = mBase + off[15:0];
            checkOutput("memAddr", memAddr, expAddr);
            checkOutput("data", data, ramByte(expAddr));
         end
      end
   end

   task automatic waitSend(input string name, input int limit);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < limit && !seen; i++) begin
         @(negedge clock);
         if (sendData) seen = 1'b1;
      end
      checkOutput(name, seen, 1'b1);
   endtask

   task automatic pulseDone(input int delay);
      repeat (delay) @(negedge clock);
      done = 1'b1;
      @(negedge clock);
      done = 1'b0;
   endtask

   task automatic applyStimulus(input int idx, input logic [4:0] len, input logic [15:0] base);
      reqLen[5*idx +: 5] = len;
      reqBase[16*idx +: 16] = base;
   endtask

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] t2Order [5];
      int sends, lastSend, failAt;

      // Reset state and single transfer with address translation.
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("rstGrant", grant, 4'b0);
      checkOutput("rstSend", sendData, 1'b0);
      checkOutput("rstLen", dataLength, 5'd0);
      applyStimulus(0, 5'd2, 16'h0100);
      req = 4'b0001;
      @(negedge clock);
      checkOutput("t1Grant", grant, 4'b0001);
      checkOutput("t1NoSendYet", sendData, 1'b0);
      req = 4'b0000;
      applyStimulus(0, 5'd7, 16'h0800);
      @(negedge clock);
      checkOutput("t1Send", sendData, 1'b1);
      checkOutput("t1Len", dataLength, 5'd2);
      dataAddr = 32'd1; byteAddr = 7'd5;
      #1;
      checkOutput("t1MemAddr", memAddr, 16'h0185);
      checkOutput("t1Data", data, 8'h85 ^ 8'h01 ^ 8'h5A);
      pulseDone(2);
      checkOutput("t1RspOk", rspOk, 4'b0001);
      checkOutput("t1GrantHeld", grant, 4'b0001);
      @(negedge clock);
      checkOutput("t1GrantDrop", grant, 4'b0000);
      dataAddr = '0; byteAddr = '0;

      // Round-robin among four held requests.
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      applyStimulus(0, 5'd1, 16'h1000);
      applyStimulus(1, 5'd2, 16'h2000);
      applyStimulus(2, 5'd3, 16'h3000);
      applyStimulus(3, 5'd4, 16'h4000);
      t2Order[0] = 4'b0001; t2Order[1] = 4'b0010; t2Order[2] = 4'b0100;
      t2Order[3] = 4'b1000; t2Order[4] = 4'b0001;
      req = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         waitSend("t2SendSeen", 40);
         checkOutput("t2Grant", grant, t2Order[t]);
         if (t == 4) req = 4'b0000;
         pulseDone(8);
      end
      repeat (3) @(negedge clock);

      // Timeout with retries exhausting, length change after latch ignored.
      applyStimulus(2, 5'd3, 16'h0200);
      req = 4'b0100;
      waitSend("t3FirstSend", 10);
      req = 4'b0000;
      reqLen[14:10] = 5'd9;
      sends = 1; lastSend = 0; failAt = -1;
      for (int t = 1; t <= 120 && failAt < 0; t++) begin
         @(negedge clock);
         if (sendData) begin
            checkOutput("t3Spacing", t - lastSend, 17);
            checkOutput("t3LenHeld", dataLength, 5'd3);
            lastSend = t;
            sends++;
         end
         if (rspFail != 4'b0) begin
            failAt = t;
            checkOutput("t3FailOwner", rspFail, 4'b0100);
         end
      end
      checkOutput("t3Sends", sends, 4);
      checkOutput("t3FailDelay", failAt - lastSend, 16);
      repeat (2) @(negedge clock);

      // Zero length rejected without launch.
      applyStimulus(1, 5'd0, 16'h0300);
      req = 4'b0010;
      @(negedge clock);
      checkOutput("t4aFail", rspFail, 4'b0010);
      checkOutput("t4aNoSend", sendData, 1'b0);
      req = 4'b0000;
      @(negedge clock);
      checkOutput("t4aGrantDrop", grant, 4'b0000);
      repeat (2) @(negedge clock);

      // Done on the same cycle as timer expiry completes ok.
      applyStimulus(3, 5'd4, 16'h0400);
      req = 4'b1000;
      waitSend("t4bSend", 10);
      req = 4'b0000;
      pulseDone(15);
      checkOutput("t4bOk", rspOk, 4'b1000);
      checkOutput("t4bNoFail", rspFail, 4'b0000);
      repeat (3) @(negedge clock);

      // Reset mid-transfer restores requester 0 priority.
      applyStimulus(0, 5'd1, 16'h0500);
      applyStimulus(1, 5'd2, 16'h0600);
      req = 4'b0001;
      waitSend("t5SendA", 10);
      req = 4'b0000;
      pulseDone(2);
      repeat (3) @(negedge clock);
      req = 4'b0010;
      waitSend("t5SendB", 10);
      req = 4'b0000;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("t5Grant", grant, 4'b0000);
      checkOutput("t5Send", sendData, 1'b0);
      checkOutput("t5Pulses", {rspOk, rspFail}, 8'h00);
      reset = 1'b0;
      req = 4'b0011;
      @(negedge clock);
      checkOutput("t5Priority", grant, 4'b0001);
      req = 4'b0000;
      waitSend("t5SendC", 10);
      pulseDone(2);
      repeat (3) @(negedge clock);

      // Base plus offset wraps at the buffer size.
      applyStimulus(0, 5'd1, 16'hFFF0);
      req = 4'b0001;
      waitSend("t6Send", 10);
      req = 4'b0000;
      dataAddr = 32'd0; byteAddr = 7'h20;
      #1;
      checkOutput("t6Wrap", memAddr, 16'h0010);
      checkOutput("t6Data", data, 8'h10 ^ 8'h00 ^ 8'h5A);
      pulseDone(2);
      repeat (3) @(negedge clock);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
